// File: rtl/spike_result_collector_pkg.sv
// Shared types for the spike result collector: FSM state encoding and the
// counter saturation helper.
package collector_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DUMP  = 2'd2
   } state_t;

   // All-ones value of a counter of the given width (width must stay below 32).
   function automatic int unsigned cnt_sat(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/spike_result_collector_if.sv
// Router-side packet port plus the result dump bus of the spike collector.
interface spike_result_collector_if #(
   parameter int unsigned ID_WIDTH       = 4,
   parameter int unsigned CNT_WIDTH      = 8,
   parameter int unsigned STEP_CNT_WIDTH = 6
);
   logic [ID_WIDTH-1:0]       packet_in;
   logic                      write_enable;
   logic                      receive_full;
   logic                      result_valid;
   logic [ID_WIDTH-1:0]       result_id;
   logic [CNT_WIDTH-1:0]      result_count;
   logic [STEP_CNT_WIDTH-1:0] result_step;

   modport master (
      output packet_in, write_enable,
      input  receive_full, result_valid, result_id, result_count, result_step
   );

   modport slave (
      input  packet_in, write_enable,
      output receive_full, result_valid, result_id, result_count, result_step
   );
endinterface

// File: rtl/spike_result_collector_sync_fifo.sv
// Small synchronous FIFO with registered occupancy; DEPTH must be a power of 2.
module sync_fifo #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // Full/empty come from the registered count, so a same-cycle pop never frees a slot.
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/spike_result_collector.sv
// Buffers spike packets, counts them per output neuron, and dumps/clears the
// counts on every time-step boundary until STEP_NUMBER steps are done.
module spike_result_collector
   import collector_pkg::*;
#(
   parameter int unsigned NUM_OUT        = 4,
   parameter int unsigned ID_WIDTH       = 4,
   parameter int unsigned CNT_WIDTH      = 8,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned STEP_NUMBER    = 32,
   parameter int unsigned STEP_CNT_WIDTH = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   spike_result_collector_if.slave  bus,
   output logic                     done,
   output logic                     drop_flag,
   output logic                     overrun_flag
);
   localparam int unsigned IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_WIDTH-1:0]      CNT_SAT   = CNT_WIDTH'(cnt_sat(CNT_WIDTH));
   localparam logic [STEP_CNT_WIDTH-1:0] STEP_LAST = STEP_CNT_WIDTH'(STEP_NUMBER - 1);
   localparam logic [IDX_W-1:0]          IDX_LAST  = IDX_W'(NUM_OUT - 1);

   state_t                    state;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [ID_WIDTH-1:0]       fifo_data;
   logic [OCC_W-1:0]          fifo_count;
   logic                      pop;
   logic                      pop_vld;
   logic [ID_WIDTH-1:0]       pop_id;
   logic                      id_ok;
   logic [CNT_WIDTH-1:0]      cnt [NUM_OUT];
   logic [IDX_W-1:0]          idx;
   logic [STEP_CNT_WIDTH-1:0] step_cnt;
   logic                      res_valid;
   logic [ID_WIDTH-1:0]       res_id;
   logic [CNT_WIDTH-1:0]      res_count;
   logic [STEP_CNT_WIDTH-1:0] res_step;

   sync_fifo #(
      .WIDTH (ID_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bus.write_enable),
      .wr_data (bus.packet_in),
      .rd_en   (pop),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign pop              = !fifo_empty && (state == IDLE || state == DRAIN);
   assign id_ok            = 32'(pop_id) < NUM_OUT;
   assign bus.receive_full = (fifo_count == OCC_W'(FIFO_DEPTH));
   assign bus.result_valid = res_valid;
   assign bus.result_id    = res_id;
   assign bus.result_count = res_count;
   assign bus.result_step  = res_step;

   // Popped id is registered first; the counter update lands one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pop_vld <= 1'b0;
         pop_id  <= '0;
      end else begin
         pop_vld <= pop;
         pop_id  <= fifo_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_OUT; i++) cnt[i] <= '0;
      end else begin
         if (pop_vld && id_ok && cnt[pop_id[IDX_W-1:0]] != CNT_SAT)
            cnt[pop_id[IDX_W-1:0]] <= cnt[pop_id[IDX_W-1:0]] + 1'b1;
         if (state == DUMP) cnt[idx] <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         step_cnt     <= '0;
         done         <= 1'b0;
         drop_flag    <= 1'b0;
         overrun_flag <= 1'b0;
         res_valid    <= 1'b0;
         res_id       <= '0;
         res_count    <= '0;
         res_step     <= '0;
      end else begin
         res_valid <= 1'b0;
         if ((bus.write_enable && fifo_full) || (pop_vld && !id_ok)) drop_flag <= 1'b1;
         if (start && state != IDLE) overrun_flag <= 1'b1;
         case (state)
            IDLE: if (start && !done) state <= DRAIN;
            DRAIN: begin
               if (fifo_count == '0) begin
                  state <= DUMP;
                  idx   <= '0;
               end
            end
            DUMP: begin
               res_valid <= 1'b1;
               res_id    <= ID_WIDTH'(idx);
               res_count <= cnt[idx];
               res_step  <= step_cnt;
               if (idx == IDX_LAST) begin
                  state    <= IDLE;
                  step_cnt <= step_cnt + 1'b1;
                  if (step_cnt == STEP_LAST) done <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spike_result_collector.sv
// Scoreboard bench for spike_result_collector: expected dumps are queued when a
// step is closed and compared as result_valid cycles appear.
module tb_spike_result_collector;
   localparam int unsigned NUM_OUT        = 4;
   localparam int unsigned ID_WIDTH       = 4;
   localparam int unsigned CNT_WIDTH      = 8;
   localparam int unsigned FIFO_DEPTH     = 4;
   localparam int unsigned STEP_NUMBER    = 2;
   localparam int unsigned STEP_CNT_WIDTH = 6;
   localparam int unsigned SAT            = (1 << CNT_WIDTH) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic done;
   logic drop_flag;
   logic overrun_flag;

   spike_result_collector_if #(
      .ID_WIDTH       (ID_WIDTH),
      .CNT_WIDTH      (CNT_WIDTH),
      .STEP_CNT_WIDTH (STEP_CNT_WIDTH)
   ) bus ();

   spike_result_collector #(
      .NUM_OUT        (NUM_OUT),
      .ID_WIDTH       (ID_WIDTH),
      .CNT_WIDTH      (CNT_WIDTH),
      .FIFO_DEPTH     (FIFO_DEPTH),
      .STEP_NUMBER    (STEP_NUMBER),
      .STEP_CNT_WIDTH (STEP_CNT_WIDTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .bus          (bus),
      .done         (done),
      .drop_flag    (drop_flag),
      .overrun_flag (overrun_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned id;
      int unsigned cnt;
      int unsigned step;
   } exp_t;

   exp_t        sb [$];
   exp_t        mon_e;
   int unsigned model_cnt [NUM_OUT];
   int          n_pass  = 0;
   int          n_total = 0;

   // Result monitor: every valid dump cycle must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.result_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_result: got valid id %0d count %0d, expected no result", bus.result_id, bus.result_count);
         end else begin
            mon_e = sb.pop_front();
            n_total++;
            if (bus.result_id !== ID_WIDTH'(mon_e.id))
               $display("FAIL result_id: got %0d expected %0d", bus.result_id, mon_e.id);
            else n_pass++;
            n_total++;
            if (bus.result_count !== CNT_WIDTH'(mon_e.cnt))
               $display("FAIL result_count[%0d]: got %0d expected %0d", mon_e.id, bus.result_count, mon_e.cnt);
            else n_pass++;
            n_total++;
            if (bus.result_step !== STEP_CNT_WIDTH'(mon_e.step))
               $display("FAIL result_step: got %0d expected %0d", bus.result_step, mon_e.step);
            else n_pass++;
         end
      end
   end

   task automatic reset_dut();
      bus.write_enable = 1'b0;
      bus.packet_in    = '0;
      start            = 1'b0;
      rst_n            = 1'b0;
      sb.delete();
      for (int i = 0; i < NUM_OUT; i++) model_cnt[i] = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send(input int unsigned id);
      int unsigned guard = 0;
      while (bus.receive_full === 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         n_total++;
         $display("FAIL send_wait: receive_full stuck at 1 for %0d cycles, expected 0", guard);
      end
      bus.packet_in    = ID_WIDTH'(id);
      bus.write_enable = 1'b1;
      if (id < NUM_OUT && model_cnt[id] < SAT) model_cnt[id]++;
      @(negedge clk);
      bus.write_enable = 1'b0;
   endtask

   task automatic push_step(input int unsigned step);
      for (int i = 0; i < NUM_OUT; i++) begin
         sb.push_back('{id: i, cnt: model_cnt[i], step: step});
         model_cnt[i] = 0;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_dump(input string name);
      int unsigned t = 0;
      while ((sb.size() != 0 || bus.result_valid === 1'b1) && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_total++;
      if (t >= 200) $display("FAIL %s_dump: %0d results still pending after %0d cycles, expected 0", name, sb.size(), t);
      else n_pass++;
   endtask

   task automatic wait_valid(input string name);
      int unsigned t = 0;
      while (bus.result_valid !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      n_total++;
      if (t >= 50) $display("FAIL %s_valid_wait: result_valid=%b after %0d cycles, expected 1", name, bus.result_valid, t);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset_dut();
      n_total++;
      if ({bus.result_valid, bus.result_id, bus.result_count, bus.result_step,
           done, drop_flag, overrun_flag, bus.receive_full} !== '0)
         $display("FAIL reset_outputs: got v=%b id=%0d cnt=%0d step=%0d done=%b drop=%b ovr=%b full=%b, expected all 0",
                  bus.result_valid, bus.result_id, bus.result_count, bus.result_step,
                  done, drop_flag, overrun_flag, bus.receive_full);
      else n_pass++;
   endtask

   task automatic test_basic();
      reset_dut();
      repeat (3) send(2);
      push_step(0);
      pulse_start();
      wait_dump("basic0");
      push_step(1);
      pulse_start();
      wait_dump("basic1");
      n_total++;
      if (done !== 1'b1) $display("FAIL basic_done: got %b expected 1", done);
      else n_pass++;
      n_total++;
      if ({bus.result_valid, bus.result_id, bus.result_count, bus.result_step} !==
          {1'b0, ID_WIDTH'(3), CNT_WIDTH'(0), STEP_CNT_WIDTH'(1)})
         $display("FAIL basic_hold: got v=%b id=%0d cnt=%0d step=%0d, expected v=0 id=3 cnt=0 step=1",
                  bus.result_valid, bus.result_id, bus.result_count, bus.result_step);
      else n_pass++;
   endtask

   task automatic test_full_during_dump();
      reset_dut();
      push_step(0);
      start = 1'b1;
      @(negedge clk);
      start            = 1'b0;
      bus.packet_in    = ID_WIDTH'(3);
      bus.write_enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 2) begin
            n_total++;
            if (bus.receive_full !== 1'b0) $display("FAIL full_after3: got %b expected 0", bus.receive_full);
            else n_pass++;
         end
         if (i == 3) begin
            n_total++;
            if (bus.receive_full !== 1'b1) $display("FAIL full_after4: got %b expected 1", bus.receive_full);
            else n_pass++;
         end
      end
      bus.write_enable = 1'b0;
      n_total++;
      if (drop_flag !== 1'b1) $display("FAIL full_drop_flag: got %b expected 1", drop_flag);
      else n_pass++;
      model_cnt[3] = 4;
      wait_dump("full0");
      push_step(1);
      pulse_start();
      wait_dump("full1");
   endtask

   task automatic test_saturation();
      reset_dut();
      repeat (300) send(1);
      n_total++;
      if (model_cnt[1] !== SAT) $display("FAIL sat_model: got %0d expected %0d", model_cnt[1], SAT);
      else n_pass++;
      push_step(0);
      pulse_start();
      wait_dump("sat");
   endtask

   task automatic test_bad_id();
      reset_dut();
      send(0);
      repeat (3) @(negedge clk);
      n_total++;
      if (drop_flag !== 1'b0) $display("FAIL badid_drop_before: got %b expected 0", drop_flag);
      else n_pass++;
      send(9);
      send(2);
      send(2);
      repeat (3) @(negedge clk);
      n_total++;
      if (drop_flag !== 1'b1) $display("FAIL badid_drop_after: got %b expected 1", drop_flag);
      else n_pass++;
      push_step(0);
      pulse_start();
      wait_dump("badid");
   endtask

   task automatic test_overrun();
      reset_dut();
      send(0);
      push_step(0);
      pulse_start();
      n_total++;
      if (overrun_flag !== 1'b0) $display("FAIL overrun_before: got %b expected 0", overrun_flag);
      else n_pass++;
      wait_valid("overrun");
      pulse_start();
      wait_dump("overrun");
      repeat (20) @(negedge clk);
      n_total++;
      if (overrun_flag !== 1'b1) $display("FAIL overrun_after: got %b expected 1", overrun_flag);
      else n_pass++;
   endtask

   task automatic test_done_and_reset();
      reset_dut();
      push_step(0);
      pulse_start();
      wait_dump("done0");
      push_step(1);
      pulse_start();
      wait_dump("done1");
      pulse_start();
      repeat (20) @(negedge clk);
      n_total++;
      if ({done, overrun_flag} !== 2'b10)
         $display("FAIL done_third_start: got done=%b overrun=%b, expected done=1 overrun=0", done, overrun_flag);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if (done !== 1'b0) $display("FAIL done_async_clear: got %b expected 0", done);
      else n_pass++;
      reset_dut();
      send(1);
      push_step(0);
      pulse_start();
      wait_valid("middump");
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({bus.result_valid, done} !== 2'b00)
         $display("FAIL middump_reset: got valid=%b done=%b, expected 0 0", bus.result_valid, done);
      else n_pass++;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      n_total++;
      if ({bus.result_valid, bus.result_step} !== '0)
         $display("FAIL middump_after: got valid=%b step=%0d, expected 0 0", bus.result_valid, bus.result_step);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_during_dump();
      test_saturation();
      test_bad_id();
      test_overrun();
      test_done_and_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
